bip_debug_unit: RTL
===================

# bip_debug_unit

Debug-output stage downstream of the BIP processor top. It watches the processor's exported program counter, accumulator and current instruction, and counts clock cycles until the HLT opcode is reached. On halt it freezes a snapshot and streams a fixed 7-byte frame to the UART transmitter through a start/done handshake. It sits between the BIP top and `uart_tx` in the BIP_UART system.

## Interface
Parameters:
- `HALT_OPCODE`, 5'b00000: value of `instruction[15:11]` that marks HLT.
- `HEADER`, 8'hA5: first byte of every frame.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset. `reset`=0 clears all state immediately.
- `PC`  in  11  processor program counter (PM address).
- `ACC`  in  16  processor accumulator.
- `instruction`  in  16  current instruction word from program memory.
- `tx_done`  in  1  one-cycle pulse from `uart_tx`: the current byte has finished.
- `tx_start`  out  1  one-cycle pulse requesting transmission of `tx_data`.
- `tx_data`  out  8  byte to transmit. Valid whenever `tx_start`=1 and held until the next `tx_start`.
- `halted`  out  1  high from the halt-detect edge until reset.
- `busy`  out  1  high while the frame is being sent (SEND or WAIT).

## Operation
- States: RUN, SEND, WAIT, DONE. Reset state is RUN.
- **RUN**
  - 16-bit cycle counter `cnt` starts at 0.
  - Each rising edge with `instruction[15:11]` != `HALT_OPCODE`: `cnt` increments, saturating at 16'hFFFF (no wrap).
  - Edge with `instruction[15:11]` == `HALT_OPCODE`: latch `snap_pc`=`PC`, `snap_acc`=`ACC`, `snap_cnt`=`cnt` (not incremented), set `halted`, byte index `idx`=0, go to SEND.
- **SEND**
  - Drive `tx_data`=byte[`idx`] and pulse `tx_start` for exactly one cycle.
  - Go to WAIT on the next edge.
- **WAIT**
  - Hold `tx_data`. `tx_start`=0.
  - On `tx_done`=1: if `idx`==6, go to DONE; else `idx`+1 and go to SEND.
- **DONE**
  - Outputs idle (`tx_start`=0, `busy`=0, `halted`=1).
  - All inputs are ignored until `reset`.
- Frame byte order:
  - 0: `HEADER`
  - 1: {5'b0, `snap_pc`[10:8]}
  - 2: `snap_pc`[7:0]
  - 3: `snap_acc`[15:8]
  - 4: `snap_acc`[7:0]
  - 5: `snap_cnt`[15:8]
  - 6: `snap_cnt`[7:0]
- After the halt edge, the snapshot registers are immune to changes on `PC`, `ACC` or `instruction`.
- `tx_done` is honoured only in WAIT. Pulses in RUN, SEND or DONE are discarded. There is no queuing.
- A `tx_done` held high across several WAIT cycles advances only once per SEND/WAIT pass. It cannot skip bytes, because every advance passes through SEND.
- Reset mid-frame (`reset` low during SEND or WAIT):
  - Return to RUN, `cnt`=0, `idx`=0.
  - `tx_start`, `busy` and `halted` drop asynchronously.
  - The partial frame is abandoned.
  - The next halt sends a complete new frame starting at `HEADER`.

## Timing
- Reset values: `tx_start`=0, `tx_data`=8'h00, `halted`=0, `busy`=0, `cnt`=0, `idx`=0.
- All outputs are registered. No combinational path exists from input to output.
- Halt latency: halt opcode sampled at edge N gives `halted`=1 and `busy`=1 after edge N, and `tx_start` high in cycle N+1 (after edge N+1).
- Byte-to-byte: `tx_done` sampled at edge M produces the next `tx_start` pulse in the cycle after edge M+1.
- Minimum frame time is 14 cycles plus 7 UART byte times.
- `busy` falls on the edge that samples the 7th `tx_done`.
- Count semantics: halt present on the first edge after reset release gives `snap_cnt`=0. Halt on the k-th edge gives `snap_cnt`=k-1, saturating at 65535.

## Test plan
- **Basic frame:** release reset; non-halt instructions for 9 edges; then `instruction`=16'h0000 with `PC`=11'h123, `ACC`=16'hBEEF. Bench `tx_done` responds 3 cycles after each `tx_start`. Required bytes: A5,01,23,BE,EF,00,09. `busy`=0 and `halted`=1 afterwards.
- **Immediate halt:** HLT present on the first edge after reset release. Required `snap_cnt`=0, so the last two bytes are 00,00. `tx_start` appears in cycle 2.
- **Saturation:** run 70000 non-halt cycles, then HLT. Required count bytes FF,FF.
- **Snapshot stability and spurious done:** after the halt edge, toggle `PC`/`ACC`/`instruction` randomly and pulse `tx_done` during SEND and in DONE. Required: frame bytes equal the values at the halt edge; no extra or skipped bytes; no `tx_start` in DONE.
- **Reset mid-frame:** assert `reset`=0 in WAIT after byte 3. Required: `tx_start`/`busy`/`halted`=0 immediately. After release, a fresh run and halt produce a full 7-byte frame starting with A5.
- **Held done:** `tx_done` held high continuously after the halt. Required: exactly 7 `tx_start` pulses, each 2 cycles apart, with correct byte order.

Source files
------------

// File: rtl/bip_debug_unit.sv
// BIP debug-output stage: counts cycles to HLT, snapshots PC/ACC/count,
// then streams a 7-byte frame to uart_tx via a start/done handshake.
module bip_debug_unit #(
    parameter logic [4:0] HALT_OPCODE = 5'b00000,
    parameter logic [7:0] HEADER      = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] PC,
    input  logic [15:0] ACC,
    input  logic [15:0] instruction,
    input  logic        tx_done,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        halted,
    output logic        busy
);

    typedef enum logic [1:0] {
        RUN,
        SEND,
        WAIT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [10:0] snap_pc_q, snap_pc_d;
    logic [15:0] snap_acc_q, snap_acc_d;
    logic [15:0] snap_cnt_q, snap_cnt_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        halted_q, halted_d;
    logic        busy_q, busy_d;
    logic        is_halt;
    logic [7:0]  frame_byte;
    logic        unused_instr;

    assign is_halt      = (instruction[15:11] == HALT_OPCODE);
    assign unused_instr = ^instruction[10:0];

    // Frame byte selected by the current byte index
    always_comb begin
        frame_byte = 8'h00;
        case (idx_q)
            3'd0:    frame_byte = HEADER;
            3'd1:    frame_byte = {5'b0, snap_pc_q[10:8]};
            3'd2:    frame_byte = snap_pc_q[7:0];
            3'd3:    frame_byte = snap_acc_q[15:8];
            3'd4:    frame_byte = snap_acc_q[7:0];
            3'd5:    frame_byte = snap_cnt_q[15:8];
            3'd6:    frame_byte = snap_cnt_q[7:0];
            default: frame_byte = 8'h00;
        endcase
    end

    // Next-state and registered-output logic for the run/send/wait/done FSM
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        snap_pc_d  = snap_pc_q;
        snap_acc_d = snap_acc_q;
        snap_cnt_d = snap_cnt_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        halted_d   = halted_q;
        busy_d     = busy_q;
        unique case (state_q)
            RUN: begin
                if (is_halt) begin
                    snap_pc_d  = PC;
                    snap_acc_d = ACC;
                    snap_cnt_d = cnt_q;
                    halted_d   = 1'b1;
                    busy_d     = 1'b1;
                    idx_d      = 3'd0;
                    state_d    = SEND;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            SEND: begin
                tx_start_d = 1'b1;
                tx_data_d  = frame_byte;
                state_d    = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    if (idx_q == 3'd6) begin
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = SEND;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
        endcase
    end

    // State register with asynchronous clear of everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            cnt_q      <= 16'd0;
            idx_q      <= 3'd0;
            snap_pc_q  <= 11'd0;
            snap_acc_q <= 16'd0;
            snap_cnt_q <= 16'd0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            halted_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            snap_pc_q  <= snap_pc_d;
            snap_acc_q <= snap_acc_d;
            snap_cnt_q <= snap_cnt_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            halted_q   <= halted_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign halted   = halted_q;
    assign busy     = busy_q;

endmodule
